gen_st_multi: RTL and testbench
===============================

Name: gen_st_multi

Overview:
Parametrised multi-channel strobe generator, the successor to the single-output gen_st tick source. It provides NCH independent channels. Each channel has a programmable period and a mode: free-run, one-shot or burst. Each channel emits single-cycle strobes on st[i] to pace downstream lab blocks such as counters, display scanners and UART samplers. Configuration uses a simple write port shared by all channels.

Parameters:
NCH, 4, number of independent strobe channels (1..16)
DIV_W, 16, width of the period register and down-counter
BURST_W, 8, width of the burst-count register
DEF_PERIOD, 50, period loaded into every channel at reset (clock cycles)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
en  in  NCH  per-channel enable, level
trig  in  NCH  per-channel start pulse (one-shot/burst modes)
cfg_we  in  1  configuration write strobe
cfg_ch  in  max(1,clog2(NCH))  target channel of the write
cfg_period  in  DIV_W  period in cycles; 0 is treated as 1
cfg_mode  in  2  0=free-run, 1=one-shot, 2=burst, 3=off
cfg_burst  in  BURST_W  strobes per burst; 0 is treated as 1
st  out  NCH  registered one-cycle strobe per channel
busy  out  NCH  channel is in RUN state

Behaviour:
- Reset (rst=1 at an edge): period=DEF_PERIOD, mode=free-run, burst=1, cnt=0, remaining=0, all channels IDLE; st=0, busy=0 on every channel.
- Per-channel FSM with two states, IDLE and RUN.
- Start condition in IDLE:
  - Free-run: en[i]=1.
  - One-shot or burst: en[i]=1 and trig[i]=1.
  - Mode off: never starts.
- On start: cnt<=P-1, where P=max(period,1). Burst only: remaining<=max(burst,1). State goes to RUN, busy<=1.
- RUN, cnt!=0: cnt<=cnt-1.
- RUN, cnt==0: st<=1 for exactly one cycle, then:
  - Free-run: cnt<=P-1 and stay in RUN.
  - One-shot: go to IDLE.
  - Burst: remaining<=remaining-1; if remaining was 1, go to IDLE, else cnt<=P-1.
- Latency: the first st rises P clocks after the edge that sampled the start condition. Later strobes repeat every P clocks. P=1 gives st high every cycle.
- busy falls on the same edge that asserts the final st (one-shot/burst).
- en[i]=0 while in RUN: go to IDLE at that edge, cnt<=0; st and busy are 0 from the next cycle. No strobe is emitted on that edge, even if cnt==0.
- trig while in RUN is ignored (no retrigger). trig while en=0 is ignored. trig in free-run mode is ignored.
- cfg_we=1 with cfg_ch<NCH: the channel's period, mode and burst registers update, and the channel aborts to IDLE at that edge (no strobe). A free-run channel with en=1 restarts on the following edge with the new period.
- cfg_we with cfg_ch>=NCH: ignored.
- Simultaneous events: rst overrides everything. cfg_we overrides start and cnt==0 on the same channel. en=0 overrides cnt==0.
- Channels are fully independent; a write to one channel never disturbs another.
- Period arithmetic is unsigned DIV_W-bit with no wrap: the maximum period is 2^DIV_W-1 cycles.

Decomposition:
- Package gen_st_pkg:
  - mode encoding constants MODE_FREE=0, MODE_ONE=1, MODE_BURST=2, MODE_OFF=3
  - FSM state encoding
  - a clog2 helper function
- Sub-module gen_st_ch holds one channel: config registers, FSM, cnt, remaining, st, busy. gen_st_multi instantiates it NCH times via generate and decodes cfg_ch into a per-channel write strobe.

Test Plan:
- Reset then en[0]=1 at default: st[0] pulses at 50, 100, 150 clocks after the en edge; busy[0]=1 throughout; other channels stay silent.
- cfg ch1 period=3, mode=one-shot; en[1]=1; trig[1] pulse → single st[1] 3 clocks later; busy[1] high 3 cycles then 0; a second trig while busy produces no extra strobe.
- cfg ch2 period=2, mode=burst, burst=4; trig → exactly 4 strobes spaced 2 clocks, then busy[2]=0; burst=0 gives 1 strobe.
- cfg ch3 period=0 in free-run → st[3] high every cycle; en[3]=0 mid-run → st[3]=0 from the next cycle, and no strobe on the disable edge.
- Free-run ch0 at period=5, rewritten to period=7 mid-count → no strobe on the write edge; next strobe 8 clocks after the write (1 restart + 7); a write with cfg_ch=NCH changes nothing.
- rst asserted mid-burst → st=0, busy=0 on the next cycle; after release, ch0 resumes at DEF_PERIOD with en held high.

Source files
------------

// File: rtl/gen_st_pkg.sv
// Shared definitions for the multi-channel strobe generator:
// mode encodings, channel FSM states and width helpers.
package gen_st_pkg;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_ONE   = 2'd1;
  localparam logic [1:0] MODE_BURST = 2'd2;
  localparam logic [1:0] MODE_OFF   = 2'd3;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

  // A single channel still needs a 1-bit select port.
  function automatic int ch_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gen_st_ch.sv
// One strobe channel: config registers, IDLE/RUN FSM,
// period down-counter, burst counter and registered strobe.
module gen_st_ch
  import gen_st_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int BURST_W    = 8,
  parameter int DEF_PERIOD = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               trig,
  input  logic               cfg_we,
  input  logic [DIV_W-1:0]   cfg_period,
  input  logic [1:0]         cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               st,
  output logic               busy
);

  logic [DIV_W-1:0]   period;
  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   cnt_n;
  logic [DIV_W-1:0]   reload;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] rem;
  logic [BURST_W-1:0] rem_n;
  logic [1:0]         mode;
  logic               start;
  logic               st_n;
  state_t             state;
  state_t             state_n;

  // A zero period behaves as a period of one.
  assign reload = (period == '0) ? '0 : period - DIV_W'(1);

  assign start = en && ((mode == MODE_FREE) ||
                 (((mode == MODE_ONE) || (mode == MODE_BURST)) && trig));

  assign busy = (state == S_RUN);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    st_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          cnt_n   = reload;
          if (mode == MODE_BURST)
            rem_n = (burst == '0) ? BURST_W'(1) : burst;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt != '0) begin
          cnt_n = cnt - DIV_W'(1);
        end else begin
          st_n = 1'b1;
          case (mode)
            MODE_FREE: cnt_n = reload;
            MODE_BURST: begin
              rem_n = rem - BURST_W'(1);
              if (rem <= BURST_W'(1))
                state_n = S_IDLE;
              else
                cnt_n = reload;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A config write aborts the channel before any start or strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= DIV_W'(DEF_PERIOD);
      mode   <= MODE_FREE;
      burst  <= BURST_W'(1);
      cnt    <= '0;
      rem    <= '0;
      state  <= S_IDLE;
      st     <= 1'b0;
    end else if (cfg_we) begin
      period <= cfg_period;
      mode   <= cfg_mode;
      burst  <= cfg_burst;
      cnt    <= '0;
      rem    <= '0;
      state  <= S_IDLE;
      st     <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      rem    <= rem_n;
      state  <= state_n;
      st     <= st_n;
    end
  end

endmodule

// File: rtl/gen_st_multi.sv
// Multi-channel strobe generator: NCH independent channels
// sharing one configuration write port.
module gen_st_multi
  import gen_st_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DIV_W      = 16,
  parameter int BURST_W    = 8,
  parameter int DEF_PERIOD = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         trig,
  input  logic                   cfg_we,
  input  logic [ch_w(NCH)-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]       cfg_period,
  input  logic [1:0]             cfg_mode,
  input  logic [BURST_W-1:0]     cfg_burst,
  output logic [NCH-1:0]         st,
  output logic [NCH-1:0]         busy
);

  localparam int CH_W = ch_w(NCH);

  // Out-of-range selects match no channel and are dropped.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic we;
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    gen_st_ch #(
      .DIV_W     (DIV_W),
      .BURST_W   (BURST_W),
      .DEF_PERIOD(DEF_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .trig      (trig[i]),
      .cfg_we    (we),
      .cfg_period(cfg_period),
      .cfg_mode  (cfg_mode),
      .cfg_burst (cfg_burst),
      .st        (st[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_gen_st_multi.sv
// Scoreboard bench for gen_st_multi: expected strobe cycles are
// queued per channel when stimulus is driven and popped on st.
module tb_gen_st_multi;

  localparam int NCH = 5;
  localparam int CHW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   trig;
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [15:0]      cfg_period;
  logic [1:0]       cfg_mode;
  logic [7:0]       cfg_burst;
  logic [NCH-1:0]   st;
  logic [NCH-1:0]   busy;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int q [NCH][$];

  gen_st_multi #(
    .NCH       (NCH),
    .DIV_W     (16),
    .BURST_W   (8),
    .DEF_PERIOD(50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .trig      (trig),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .cfg_burst (cfg_burst),
    .st        (st),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the head of its channel queue.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      while (q[c].size() > 0 && q[c][0] < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL st_ch%0d: no strobe at cycle %0d, required one",
                 c, q[c].pop_front());
      end
      if (st[c]) begin
        compared++;
        if (q[c].size() == 0) begin
          mismatched++;
          $display("FAIL st_ch%0d: strobe at cycle %0d, required none",
                   c, cyc);
        end else begin
          int e;
          e = q[c].pop_front();
          if (e !== cyc) begin
            mismatched++;
            $display("FAIL st_ch%0d: strobe at cycle %0d, required %0d",
                     c, cyc, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int p,
                     input logic [1:0] m, input int b);
    cfg_ch     = CHW'(ch);
    cfg_period = 16'(p);
    cfg_mode   = m;
    cfg_burst  = 8'(b);
    cfg_we     = 1'b1;
    tick(1);
    cfg_we     = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < NCH; c++) begin
      compared++;
      if (q[c].size() != 0) begin
        mismatched++;
        $display("FAIL %s_drain_ch%0d: %0d strobes outstanding, required 0",
                 name, c, q[c].size());
        q[c].delete();
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    compared++;
    if (st !== '0) begin
      mismatched++;
      $display("FAIL reset_st: got %b, required %b", st, 5'b0);
    end
    compared++;
    if (busy !== '0) begin
      mismatched++;
      $display("FAIL reset_busy: got %b, required %b", busy, 5'b0);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_free_default();
    int n;
    n = cyc;
    en[0] = 1'b1;
    q[0].push_back(n + 51);
    q[0].push_back(n + 101);
    q[0].push_back(n + 151);
    tick(1);
    compared++;
    if (busy !== 5'b00001) begin
      mismatched++;
      $display("FAIL free_busy_a: got %b, required %b", busy, 5'b00001);
    end
    tick(75);
    compared++;
    if (busy !== 5'b00001) begin
      mismatched++;
      $display("FAIL free_busy_b: got %b, required %b", busy, 5'b00001);
    end
    tick(75);
    en[0] = 1'b0;
    tick(2);
    compared++;
    if (busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL free_busy_off: got %b, required 0", busy[0]);
    end
    drain("free");
  endtask

  task automatic test_one_shot();
    int n;
    cfg(1, 3, 2'd1, 1);
    en[1] = 1'b1;
    n = cyc;
    trig[1] = 1'b1;
    q[1].push_back(n + 4);
    tick(1);
    trig[1] = 1'b0;
    compared++;
    if (busy[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL one_busy_start: got %b, required 1", busy[1]);
    end
    tick(1);
    trig[1] = 1'b1;
    tick(1);
    trig[1] = 1'b0;
    compared++;
    if (busy[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL one_busy_mid: got %b, required 1", busy[1]);
    end
    tick(1);
    compared++;
    if (busy[1] !== 1'b0 || st[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL one_final: busy=%b st=%b, required busy=0 st=1",
               busy[1], st[1]);
    end
    tick(10);
    drain("one");
  endtask

  task automatic test_burst();
    int n;
    cfg(2, 2, 2'd2, 4);
    en[2] = 1'b1;
    n = cyc;
    trig[2] = 1'b1;
    for (int k = 0; k < 4; k++)
      q[2].push_back(n + 3 + 2 * k);
    tick(1);
    trig[2] = 1'b0;
    tick(7);
    compared++;
    if (busy[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL burst_busy_mid: got %b, required 1", busy[2]);
    end
    tick(1);
    compared++;
    if (busy[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL burst_busy_end: got %b, required 0", busy[2]);
    end
    tick(4);
    drain("burst4");
    cfg(2, 2, 2'd2, 0);
    n = cyc;
    trig[2] = 1'b1;
    q[2].push_back(n + 3);
    tick(1);
    trig[2] = 1'b0;
    tick(12);
    compared++;
    if (busy[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL burst0_busy: got %b, required 0", busy[2]);
    end
    drain("burst0");
  endtask

  task automatic test_fast_disable();
    int n;
    cfg(3, 0, 2'd0, 1);
    n = cyc;
    en[3] = 1'b1;
    for (int k = 0; k < 8; k++)
      q[3].push_back(n + 2 + k);
    tick(9);
    en[3] = 1'b0;
    tick(1);
    compared++;
    if (st[3] !== 1'b0 || busy[3] !== 1'b0) begin
      mismatched++;
      $display("FAIL fast_disable: st=%b busy=%b, required 0 0",
               st[3], busy[3]);
    end
    tick(3);
    drain("fast");
  endtask

  task automatic test_rewrite();
    int n;
    int w;
    cfg(0, 5, 2'd0, 1);
    n = cyc;
    en[0] = 1'b1;
    q[0].push_back(n + 6);
    q[0].push_back(n + 11);
    tick(15);
    cfg(0, 7, 2'd0, 1);
    w = cyc;
    q[0].push_back(w + 8);
    q[0].push_back(w + 15);
    tick(14);
    cfg(NCH, 2, 2'd3, 1);
    q[0].push_back(w + 22);
    q[0].push_back(w + 29);
    compared++;
    if (busy[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL rewrite_ignored_busy: got %b, required 1", busy[0]);
    end
    tick(14);
    en[0] = 1'b0;
    tick(2);
    drain("rewrite");
  endtask

  task automatic test_reset_mid();
    int n;
    int m;
    cfg(2, 2, 2'd2, 4);
    n = cyc;
    trig[2] = 1'b1;
    en[0] = 1'b1;
    q[2].push_back(n + 3);
    q[2].push_back(n + 5);
    tick(1);
    trig[2] = 1'b0;
    tick(5);
    rst = 1'b1;
    en = 5'b00001;
    tick(1);
    compared++;
    if (st !== '0 || busy !== '0) begin
      mismatched++;
      $display("FAIL rst_mid: st=%b busy=%b, required 0 0", st, busy);
    end
    rst = 1'b0;
    m = cyc;
    q[0].push_back(m + 51);
    q[0].push_back(m + 101);
    tick(2);
    compared++;
    if (busy !== 5'b00001) begin
      mismatched++;
      $display("FAIL rst_resume_busy: got %b, required %b", busy, 5'b00001);
    end
    tick(99);
    en[0] = 1'b0;
    tick(2);
    drain("rst_mid");
  endtask

  initial begin
    rst        = 1'b1;
    en         = '0;
    trig       = '0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_mode   = '0;
    cfg_burst  = '0;
    test_reset();
    test_free_default();
    test_one_shot();
    test_burst();
    test_fast_disable();
    test_rewrite();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
